lcd_view_sequencer: RTL and testbench

- Upstream stage of the LCD glyph controller; it produces that controller's 4-bit select_figures word.
- Derives the pet mood from four stat levels and rotates the displayed stat icon on a seconds timebase.
- Pre-empts the rotation with a timed alert view whenever a stat drops.
- All outputs are registered and stable for whole seconds, far slower than the LCD refresh loop.

---
 rtl/tamagotchi_lcd_pkg.sv | 36 +++
 rtl/tick_gen.sv | 38 +++
 rtl/lcd_view_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_lcd_view_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/tamagotchi_lcd_pkg.sv
// ============================================================================
// Module      : tamagotchi_lcd_pkg
// Description : Mood/stat codes and view-state encoding shared with the LCD
//               controller's figure decoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tamagotchi_lcd_pkg;

    localparam int NUM_STATS = 4;

    typedef enum logic [1:0] {
        MOOD_SAD     = 2'b00,
        MOOD_HAPPY   = 2'b01,
        MOOD_NEUTRAL = 2'b10
    } mood_e;

    // Stat codes double as rotation indices, so they stay plain 2-bit values.
    localparam logic [1:0] STAT_HEALTH = 2'b00;
    localparam logic [1:0] STAT_ENERGY = 2'b01;
    localparam logic [1:0] STAT_FOOD   = 2'b10;
    localparam logic [1:0] STAT_FUN    = 2'b11;

    typedef enum logic [0:0] {
        ST_ROTATE = 1'b0,
        ST_ALERT  = 1'b1
    } view_state_e;

    function automatic logic [1:0] stat_inc(input logic [1:0] s);
        return s + 2'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// ============================================================================
// Module      : tick_gen
// Description : Free-running divider giving a one-cycle strobe every TICK_DIV
//               clocks; cleared only by reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_gen #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             last_w;

    assign last_w = (cnt_q == CNT_LAST);
    assign cnt_d  = last_w ? '0 : cnt_q + CNT_W'(1);
    assign tick   = last_w;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/lcd_view_sequencer.sv
// ============================================================================
// Module      : lcd_view_sequencer
// Description : Derives pet mood from four stat levels, rotates the shown stat
//               each few seconds and pre-empts rotation with a timed alert view.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_view_sequencer
    import tamagotchi_lcd_pkg::*;
#(
    parameter int LEVEL_W      = 3,
    parameter int MAX_LEVEL    = 5,
    parameter int TICK_DIV     = 50000000,
    parameter int ROTATE_SEC   = 3,
    parameter int ALERT_SEC    = 5,
    parameter int SAD_THRESH   = 1,
    parameter int HAPPY_THRESH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [LEVEL_W-1:0] health,
    input  logic [LEVEL_W-1:0] food,
    input  logic [LEVEL_W-1:0] energy,
    input  logic [LEVEL_W-1:0] fun,
    output logic [3:0]         select_figures,
    output logic               view_changed,
    output logic               alert
);

    localparam int SEC_MAX = (ROTATE_SEC > ALERT_SEC) ? ROTATE_SEC : ALERT_SEC;
    localparam int SEC_W   = (SEC_MAX > 1) ? $clog2(SEC_MAX) : 1;

    localparam logic [SEC_W-1:0]   ROT_LAST   = SEC_W'(ROTATE_SEC - 1);
    localparam logic [SEC_W-1:0]   ALERT_LAST = SEC_W'(ALERT_SEC - 1);
    localparam logic [LEVEL_W-1:0] LVL_MAX    = LEVEL_W'(MAX_LEVEL);
    localparam logic [LEVEL_W-1:0] LVL_SAD    = LEVEL_W'(SAD_THRESH);
    localparam logic [LEVEL_W-1:0] LVL_HAPPY  = LEVEL_W'(HAPPY_THRESH);

    // Level pipeline, indexed by stat code
    logic [LEVEL_W-1:0]   raw_w  [NUM_STATS];
    logic [LEVEL_W-1:0]   sat_w  [NUM_STATS];
    logic [LEVEL_W-1:0]   lvl_q  [NUM_STATS];
    logic [LEVEL_W-1:0]   prev_q [NUM_STATS];
    logic [NUM_STATS-1:0] dec_w;
    logic [NUM_STATS-1:0] sad_w;
    logic [NUM_STATS-1:0] happy_w;

    logic                 tick_w;
    mood_e                mood_w;
    logic [1:0]           dec_stat_w;

    // View state
    view_state_e          state_q,      state_d;
    logic [1:0]           idx_q,        idx_d;
    logic [SEC_W-1:0]     sec_q,        sec_d;
    logic [1:0]           alert_stat_q, alert_stat_d;
    logic [3:0]           sf_q,         sf_d;
    logic                 vc_q,         vc_d;
    logic [1:0]           stat_d;

    assign raw_w[STAT_HEALTH] = health;
    assign raw_w[STAT_ENERGY] = energy;
    assign raw_w[STAT_FOOD]   = food;
    assign raw_w[STAT_FUN]    = fun;

    generate
        for (genvar i = 0; i < NUM_STATS; i++) begin : g_stat
            assign sat_w[i]   = (raw_w[i] > LVL_MAX) ? LVL_MAX : raw_w[i];
            assign dec_w[i]   = (lvl_q[i] < prev_q[i]);
            assign sad_w[i]   = (lvl_q[i] <= LVL_SAD);
            assign happy_w[i] = (lvl_q[i] >= LVL_HAPPY);
        end
    endgenerate

    // prev follows lvl by one cycle, so a decrease shows as a single-cycle dec
    always_ff @(posedge clk) begin
        lvl_q <= sat_w;
        if (!reset) begin
            prev_q <= sat_w;
        end else begin
            prev_q <= lvl_q;
        end
    end

    always_comb begin
        mood_w = MOOD_NEUTRAL;
        if (|sad_w) begin
            mood_w = MOOD_SAD;
        end else if (&happy_w) begin
            mood_w = MOOD_HAPPY;
        end
    end

    always_comb begin
        dec_stat_w = STAT_FUN;
        if (dec_w[STAT_HEALTH]) begin
            dec_stat_w = STAT_HEALTH;
        end else if (dec_w[STAT_FOOD]) begin
            dec_stat_w = STAT_FOOD;
        end else if (dec_w[STAT_ENERGY]) begin
            dec_stat_w = STAT_ENERGY;
        end
    end

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_w)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        sec_d        = sec_q;
        alert_stat_d = alert_stat_q;

        // A fresh decrease overrides any tick handling in the same cycle
        if (|dec_w) begin
            state_d      = ST_ALERT;
            alert_stat_d = dec_stat_w;
            sec_d        = '0;
        end else if (tick_w) begin
            case (state_q)
                ST_ROTATE: begin
                    if (sec_q == ROT_LAST) begin
                        idx_d = stat_inc(idx_q);
                        sec_d = '0;
                    end else begin
                        sec_d = sec_q + SEC_W'(1);
                    end
                end
                ST_ALERT: begin
                    if (sec_q == ALERT_LAST) begin
                        state_d = ST_ROTATE;
                        idx_d   = stat_inc(alert_stat_q);
                        sec_d   = '0;
                    end else begin
                        sec_d = sec_q + SEC_W'(1);
                    end
                end
                default: begin
                    state_d = ST_ROTATE;
                    sec_d   = '0;
                end
            endcase
        end

        stat_d = (state_d == ST_ALERT) ? alert_stat_d : idx_d;
        sf_d   = {mood_w, stat_d};
        vc_d   = (sf_d != sf_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_ROTATE;
            idx_q        <= STAT_HEALTH;
            sec_q        <= '0;
            alert_stat_q <= STAT_HEALTH;
            sf_q         <= {MOOD_NEUTRAL, STAT_HEALTH};
            vc_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            sec_q        <= sec_d;
            alert_stat_q <= alert_stat_d;
            sf_q         <= sf_d;
            vc_q         <= vc_d;
        end
    end

    assign select_figures = sf_q;
    assign view_changed   = vc_q;
    assign alert          = (state_q == ST_ALERT);

endmodule

`default_nettype wire

// File: tb/tb_lcd_view_sequencer.sv
// ============================================================================
// Module      : tb_lcd_view_sequencer
// Description : Directed stimulus with a queue of expected view changes,
//               popped by a monitor on every view_changed pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcd_view_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] health, food, energy, fun;
    logic [3:0] select_figures;
    logic       view_changed;
    logic       alert;

    lcd_view_sequencer #(
        .LEVEL_W      (3),
        .MAX_LEVEL    (5),
        .TICK_DIV     (4),
        .ROTATE_SEC   (2),
        .ALERT_SEC    (3),
        .SAD_THRESH   (1),
        .HAPPY_THRESH (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .health         (health),
        .food           (food),
        .energy         (energy),
        .fun            (fun),
        .select_figures (select_figures),
        .view_changed   (view_changed),
        .alert          (alert)
    );

    always #5 clk = ~clk;

    int unsigned gcyc = 0;
    always @(posedge clk) gcyc <= gcyc + 1;

    typedef struct {
        logic [3:0]  sf;
        logic        al;
        int unsigned at;
        string       nm;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned base = 0;
    int unsigned cyc = 0;

    task automatic step_to(input int unsigned n);
        while (cyc < n) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    task automatic expect_view(input logic [3:0] sf, input logic al,
                               input int unsigned n, input string nm);
        exp_q.push_back('{sf: sf, al: al, at: base + n, nm: nm});
    endtask

    task automatic check_now(input string nm, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, req);
        end
    endtask

    // Monitor: every view_changed pulse must match the next queued view
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (view_changed === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_view: got sf=%b alert=%b at cycle %0d, expected no change",
                             select_figures, alert, gcyc);
                end else begin
                    e = exp_q.pop_front();
                    if (select_figures !== e.sf || alert !== e.al || gcyc != e.at) begin
                        errors++;
                        $display("FAIL %s: got sf=%b alert=%b cycle=%0d expected sf=%b alert=%b cycle=%0d",
                                 e.nm, select_figures, alert, gcyc, e.sf, e.al, e.at);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin : stimulus
        health = 3'd3; food = 3'd3; energy = 3'd3; fun = 3'd3;
        reset  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        base = gcyc;
        cyc  = 0;
        check_now("reset_sf",    select_figures, 4'b1000);
        check_now("reset_alert", {3'b0, alert}, 4'd0);
        check_now("reset_vc",    {3'b0, view_changed}, 4'd0);
        reset = 1'b1;

        // Plain rotation, neutral mood, a new stat every 8 clocks
        expect_view(4'b1001, 1'b0, 8,  "rot_energy");
        expect_view(4'b1010, 1'b0, 16, "rot_food");
        expect_view(4'b1011, 1'b0, 24, "rot_fun");
        expect_view(4'b1000, 1'b0, 32, "rot_wrap");

        // Happy mood, then fun drop -> sad and fun alert
        step_to(32);
        health = 3'd5; energy = 3'd5; food = 3'd4; fun = 3'd5;
        expect_view(4'b0100, 1'b0, 34, "mood_happy");
        step_to(35);
        fun = 3'd1;
        expect_view(4'b0011, 1'b1, 37, "mood_sad_alert_fun");
        expect_view(4'b0000, 1'b0, 48, "alert_fun_expire");

        // Health 7 saturates to 5, so returning to 5 is not a drop
        step_to(48);
        health = 3'd7; fun = 3'd5;
        expect_view(4'b0100, 1'b0, 50, "sat_happy");
        expect_view(4'b0101, 1'b0, 56, "sat_no_alert_rot");
        step_to(50);
        health = 3'd5;

        // Food drop while showing energy
        step_to(57);
        food = 3'd3;
        expect_view(4'b1010, 1'b1, 59, "alert_food");
        expect_view(4'b1011, 1'b0, 68, "resume_fun");

        // Health+fun drop, then energy drop on a tick restarts the hold
        step_to(69);
        health = 3'd4; fun = 3'd4;
        expect_view(4'b1000, 1'b1, 71, "alert_prio_health");
        step_to(74);
        energy = 3'd4;
        expect_view(4'b1001, 1'b1, 76, "alert_restart_energy");
        expect_view(4'b1010, 1'b0, 88, "resume_food");

        // Reset in the middle of an alert
        step_to(89);
        fun = 3'd3;
        expect_view(4'b1011, 1'b1, 91, "alert_fun2");
        step_to(92);
        reset = 1'b0;
        health = 3'd2; energy = 3'd2; food = 3'd2; fun = 3'd3;
        step_to(93);
        check_now("midalert_reset_sf",    select_figures, 4'b1000);
        check_now("midalert_reset_alert", {3'b0, alert}, 4'd0);
        check_now("midalert_reset_vc",    {3'b0, view_changed}, 4'd0);
        step_to(94);
        reset = 1'b1;
        base  = gcyc;
        cyc   = 0;

        // No alert after release; raising levels only changes mood
        expect_view(4'b1001, 1'b0, 8, "post_reset_rot");
        step_to(3);
        check_now("post_reset_no_alert", {3'b0, alert}, 4'd0);
        step_to(9);
        health = 3'd4; energy = 3'd4; food = 3'd4; fun = 3'd4;
        expect_view(4'b0101, 1'b0, 11, "raise_happy");
        expect_view(4'b0110, 1'b0, 16, "raise_rot_food");
        step_to(13);
        check_now("raise_no_alert", {3'b0, alert}, 4'd0);

        step_to(20);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_views: got %0d unseen view changes, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
